deca_qsys_irq_ctrl: RTL and testbench



---
 rtl/deca_qsys_irq_pkg.sv | 16 +
 rtl/deca_qsys_irq_sync.sv | 30 +++
 rtl/deca_qsys_irq_ctrl.sv | 122 ++++++++++++
 tb/tb_deca_qsys_irq_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/deca_qsys_irq_pkg.sv
// Shared constants for the interrupt aggregator: register map, ACTIVE word layout,
// and the width of the pending-source index.
package deca_qsys_irq_pkg;

  localparam int DATA_W           = 16;
  localparam int IDX_W            = 4;
  localparam int ACTIVE_VALID_BIT = 15;

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
  localparam logic [2:0] ADDR_RAW      = 3'd4;
  localparam logic [2:0] ADDR_FORCE    = 3'd5;

endpackage

// File: rtl/deca_qsys_irq_sync.sv
// Multi-flop synchroniser for a vector of asynchronous irq lines; every bit gets
// its own STAGES-deep chain and all chains clear on reset.
module deca_qsys_irq_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        stage[s] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int s = 1; s < STAGES; s++) begin
        stage[s] <= stage[s-1];
      end
    end
  end

  assign dout = stage[STAGES-1];

endmodule

// File: rtl/deca_qsys_irq_ctrl.sv
// Interrupt aggregator: synchronises source lines, latches them as level or edge
// events, masks them into one registered irq and exposes them on a 16-bit slave port.
module deca_qsys_irq_ctrl
  import deca_qsys_irq_pkg::*;
#(
  parameter int                 NUM_IRQ     = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] EDGE_RESET  = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  logic [NUM_IRQ-1:0] sync;
  logic [NUM_IRQ-1:0] hist;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] edge_sel;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] wdata;
  logic [DATA_W-1:0]  read_mux;
  logic               wr_any;
  logic               wr_pending;
  logic               wr_mask;
  logic               wr_edge_sel;
  logic               wr_force;
  logic               unused_wdata;

  deca_qsys_irq_sync #(
    .WIDTH  (NUM_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (irq_in),
    .dout  (sync)
  );

  assign wr_any       = chipselect && !write_n;
  assign wr_pending   = wr_any && (address == ADDR_PENDING);
  assign wr_mask      = wr_any && (address == ADDR_MASK);
  assign wr_edge_sel  = wr_any && (address == ADDR_EDGE_SEL);
  assign wr_force     = wr_any && (address == ADDR_FORCE);
  assign wdata        = writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^writedata[DATA_W-1:NUM_IRQ];

  assign rise   = sync & ~hist;
  assign active = pending & mask;

  // Lower index wins; returns 0 when nothing is set.
  function automatic logic [IDX_W-1:0] lowest_index(input logic [NUM_IRQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Edge-mode set beats clear, so an event arriving with a W1C is never lost.
  always_comb begin
    pending_next = pending;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!edge_sel[i]) begin
        pending_next[i] = sync[i];
      end else if (rise[i] || (wr_force && wdata[i])) begin
        pending_next[i] = 1'b1;
      end else if (wr_pending && wdata[i]) begin
        pending_next[i] = 1'b0;
      end
    end
  end

  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_PENDING:  read_mux = DATA_W'(pending);
      ADDR_MASK:     read_mux = DATA_W'(mask);
      ADDR_EDGE_SEL: read_mux = DATA_W'(edge_sel);
      ADDR_ACTIVE: begin
        read_mux[ACTIVE_VALID_BIT] = |active;
        read_mux[IDX_W-1:0]        = lowest_index(active);
      end
      ADDR_RAW:      read_mux = DATA_W'(sync);
      default:       read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist     <= '0;
      pending  <= '0;
      mask     <= '0;
      edge_sel <= EDGE_RESET;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      hist     <= sync;
      pending  <= pending_next;
      readdata <= read_mux;
      irq      <= |active;
      if (wr_mask) begin
        mask <= wdata;
      end
      if (wr_edge_sel) begin
        edge_sel <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_deca_qsys_irq_ctrl.sv
// Directed and randomised bench for deca_qsys_irq_ctrl; every cycle is compared
// against a cycle-level reference model of the register-level behaviour.
module tb_deca_qsys_irq_ctrl;

  localparam int             N  = 8;
  localparam int             SS = 2;
  localparam logic [N-1:0]   ER = '0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [15:0]   writedata = '0;
  logic [15:0]   readdata;
  logic [N-1:0]  irq_in = '0;
  logic          irq;

  int checks = 0;
  int errors = 0;

  logic [N-1:0]  m_pend, m_mask, m_esel;
  logic [N-1:0]  m_smp [SS+1];
  logic [15:0]   m_rd;
  logic          m_irq;

  deca_qsys_irq_ctrl #(
    .NUM_IRQ     (N),
    .SYNC_STAGES (SS),
    .EDGE_RESET  (ER)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] active_word(input logic [N-1:0] v);
    int k;
    if (v == '0) return 16'h0000;
    k = 0;
    while (((v >> k) & 1) == 0) k++;
    return 16'h8000 + 16'(k);
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_mask = '0;
    m_esel = ER;
    m_rd   = '0;
    m_irq  = 1'b0;
    for (int k = 0; k <= SS; k++) m_smp[k] = '0;
  endtask

  // One clock: predict from the pre-edge state and inputs, then compare after the edge.
  task automatic cycle();
    logic [N-1:0] sync, hist, rise, wd, np, nm, ne, sample;
    logic [15:0]  rd;
    logic         ni, wr;
    sync   = m_smp[SS-1];
    hist   = m_smp[SS];
    rise   = sync & ~hist;
    wr     = chipselect && !write_n;
    wd     = writedata[N-1:0];
    sample = irq_in;
    case (address)
      3'd0:    rd = 16'(m_pend);
      3'd1:    rd = 16'(m_mask);
      3'd2:    rd = 16'(m_esel);
      3'd3:    rd = active_word(m_pend & m_mask);
      3'd4:    rd = 16'(sync);
      default: rd = 16'h0000;
    endcase
    ni = ((m_pend & m_mask) != '0);
    np = m_pend;
    for (int i = 0; i < N; i++) begin
      if (!m_esel[i])                                      np[i] = sync[i];
      else if (rise[i] || (wr && address == 3'd5 && wd[i])) np[i] = 1'b1;
      else if (wr && address == 3'd0 && wd[i])              np[i] = 1'b0;
    end
    nm = (wr && address == 3'd1) ? wd : m_mask;
    ne = (wr && address == 3'd2) ? wd : m_esel;
    @(posedge clk);
    #1;
    m_pend = np; m_mask = nm; m_esel = ne; m_rd = rd; m_irq = ni;
    for (int k = SS; k > 0; k--) m_smp[k] = m_smp[k-1];
    m_smp[0] = sample;
    check("irq", {15'b0, irq}, {15'b0, m_irq});
    check("readdata", readdata, m_rd);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a);
    address = a;
    cycle();
  endtask

  initial begin
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("reset_readdata", readdata, 16'h0000);
    check("reset_irq", {15'b0, irq}, 16'h0000);

    // Asynchronous reset mid-cycle with MASK populated
    wr_reg(3'd1, 16'h00FF);
    rd_reg(3'd1);
    check("mask_readback", readdata, 16'h00FF);
    #2 reset = 1'b1;
    #1;
    check("async_clear_readdata", readdata, 16'h0000);
    check("async_clear_irq", {15'b0, irq}, 16'h0000);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a));
      check("post_reset_read", readdata, (a == 2) ? 16'(ER) : 16'h0000);
    end

    // Level path: 4-edge latency both ways, W1C ignored
    wr_reg(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    repeat (3) cycle();
    check("level_irq_early", {15'b0, irq}, 16'h0000);
    cycle();
    check("level_irq_set", {15'b0, irq}, 16'h0001);
    rd_reg(3'd3);
    check("level_active", readdata, 16'h8000);
    wr_reg(3'd0, 16'h0001);
    rd_reg(3'd0);
    check("level_no_clear", readdata, 16'h0001);
    irq_in[0] = 1'b0;
    repeat (3) cycle();
    check("level_irq_hold", {15'b0, irq}, 16'h0001);
    cycle();
    check("level_irq_drop", {15'b0, irq}, 16'h0000);

    // Edge latch and W1C
    wr_reg(3'd2, 16'h0004);
    wr_reg(3'd1, 16'h0004);
    irq_in[2] = 1'b1;
    cycle();
    irq_in[2] = 1'b0;
    repeat (3) cycle();
    rd_reg(3'd0);
    check("edge_pending", readdata, 16'h0004);
    rd_reg(3'd3);
    check("edge_active", readdata, 16'h8002);
    check("edge_irq", {15'b0, irq}, 16'h0001);
    wr_reg(3'd0, 16'h0004);
    rd_reg(3'd0);
    check("edge_cleared", readdata, 16'h0000);
    check("edge_irq_cleared", {15'b0, irq}, 16'h0000);

    // Rise lands on the same edge as the clear
    irq_in[2] = 1'b1;
    cycle();
    irq_in[2] = 1'b0;
    cycle();
    wr_reg(3'd0, 16'h0004);
    rd_reg(3'd0);
    check("set_beats_clear", readdata, 16'h0004);

    // Priority and mask
    wr_reg(3'd0, 16'h00FF);
    wr_reg(3'd2, 16'h002E);
    wr_reg(3'd5, 16'h002A);
    wr_reg(3'd1, 16'h0028);
    rd_reg(3'd3);
    check("prio_3", readdata, 16'h8003);
    wr_reg(3'd1, 16'h0020);
    rd_reg(3'd3);
    check("prio_5", readdata, 16'h8005);
    wr_reg(3'd1, 16'h0000);
    rd_reg(3'd3);
    check("prio_none", readdata, 16'h0000);
    check("prio_irq_off", {15'b0, irq}, 16'h0000);

    // FORCE ignored for level-mode sources
    wr_reg(3'd0, 16'h00FF);
    wr_reg(3'd2, 16'h0080);
    wr_reg(3'd5, 16'h0081);
    rd_reg(3'd0);
    check("force_edge_only", readdata, 16'h0080);

    // Randomised traffic against the model
    repeat (600) begin
      irq_in = irq_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
      address   = 3'($urandom_range(0, 7));
      writedata = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'b1; write_n = 1'b0;
      end else begin
        chipselect = 1'($urandom); write_n = 1'b1;
      end
      cycle();
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
